// File: rtl/image_stream_loader_pkg.sv
// rtl/image_stream_loader_pkg.sv - shared constants and types for the image stream loader
// Purpose : image geometry, quantizer zero point, pixel and FSM state types.
// Ports   : none (package).
package image_stream_loader_pkg;

  localparam int IMG_H          = 28;
  localparam int IMG_W          = 28;
  localparam int ZERO_POINT_DEF = 128;
  localparam int ROW_W          = $clog2(IMG_H);
  localparam int COL_W          = $clog2(IMG_W);

  typedef logic signed [7:0] pixel_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    DRAIN  = 2'd1,
    LOADED = 2'd2
  } loader_state_t;

endpackage

// File: rtl/image_stream_loader_if.sv
// rtl/image_stream_loader_if.sv - raster pixel stream handshake bundle
// Purpose : valid/ready/last pixel stream between upstream feeder and loader.
// Ports   : s_valid, s_data[7:0], s_last driven by master; s_ready driven by slave.
interface image_stream_loader_if;

  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/image_stream_loader_pixel_quantizer.sv
// rtl/image_stream_loader_pixel_quantizer.sv - unsigned pixel to saturated int8
// Purpose : q = clamp(i_data - ZERO_POINT, -128, 127), evaluated in 10-bit signed.
// Ports   : i_data[7:0] raw unsigned pixel in; o_q signed int8 out (combinational).
module pixel_quantizer
  import image_stream_loader_pkg::*;
#(
  parameter int ZERO_POINT = ZERO_POINT_DEF
) (
  input  logic [7:0] i_data,
  output pixel_t     o_q
);

  localparam logic signed [9:0] ZP = 10'(ZERO_POINT);

  logic signed [9:0] w_diff;

  always_comb begin
    // Two guard bits keep 0..255 minus any 8-bit zero point free of overflow.
    w_diff = $signed({2'b00, i_data}) - ZP;
    if (w_diff > 10'sd127) begin
      o_q = 8'sd127;
    end else if (w_diff < -10'sd128) begin
      o_q = -8'sd128;
    end else begin
      o_q = w_diff[7:0];
    end
  end

endmodule

// File: rtl/image_stream_loader.sv
// rtl/image_stream_loader.sv - fills a 28x28 int8 image buffer from a pixel stream
// Purpose : quantizes raster pixels into a registered image, flags framing errors,
//           holds a complete frame until the consumer releases it.
// Ports   : clk, reset (async, active-low); s_if slave stream (s_valid/s_ready/s_data/s_last);
//           image[IMG_H][IMG_W] quantized buffer; image_loaded level; frame_release in;
//           frame_err one-cycle pulse; frame_count[15:0] completed frames (wraps).
module image_stream_loader
  import image_stream_loader_pkg::*;
#(
  parameter int ZERO_POINT = ZERO_POINT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  image_stream_loader_if.slave  s_if,
  output pixel_t                image [IMG_H][IMG_W],
  output logic                  image_loaded,
  input  logic                  frame_release,
  output logic                  frame_err,
  output logic [15:0]           frame_count
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  loader_state_t    r_state;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  pixel_t           r_image [IMG_H][IMG_W];
  logic             r_image_loaded;
  logic             r_frame_err;
  logic [15:0]      r_frame_count;

  logic   w_ready;
  logic   w_beat;
  logic   w_last_pos;
  pixel_t w_q;

  pixel_quantizer #(
    .ZERO_POINT (ZERO_POINT)
  ) u_quant (
    .i_data (s_if.s_data),
    .o_q    (w_q)
  );

  // Ready depends on state only, so upstream never sees a path from its own valid.
  assign w_ready     = (r_state != LOADED);
  assign s_if.s_ready = w_ready;
  assign w_beat      = s_if.s_valid && w_ready;
  assign w_last_pos  = (r_row == ROW_LAST) && (r_col == COL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= FILL;
      r_row          <= '0;
      r_col          <= '0;
      r_image_loaded <= 1'b0;
      r_frame_err    <= 1'b0;
      r_frame_count  <= '0;
      for (int r = 0; r < IMG_H; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          r_image[r][c] <= '0;
        end
      end
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_beat) begin
            r_image[r_row][r_col] <= w_q;
            if (w_last_pos) begin
              r_row <= '0;
              r_col <= '0;
              if (s_if.s_last) begin
                r_state        <= LOADED;
                r_image_loaded <= 1'b1;
                r_frame_count  <= r_frame_count + 16'd1;
              end else begin
                // Frame overran: throw away the rest up to its s_last.
                r_frame_err <= 1'b1;
                r_state     <= DRAIN;
              end
            end else if (s_if.s_last) begin
              // Short frame: keep the partial data, restart at (0,0).
              r_frame_err <= 1'b1;
              r_row       <= '0;
              r_col       <= '0;
            end else if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_beat && s_if.s_last) begin
            r_state <= FILL;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        LOADED: begin
          if (frame_release) begin
            r_state        <= FILL;
            r_image_loaded <= 1'b0;
          end
        end
        default: begin
          r_state <= FILL;
          r_row   <= '0;
          r_col   <= '0;
        end
      endcase
    end
  end

  assign image        = r_image;
  assign image_loaded = r_image_loaded;
  assign frame_err    = r_frame_err;
  assign frame_count  = r_frame_count;

endmodule
